// File: rtl/fpu_issuer_if.sv
// Request/response/FPU-drive bundle for fpu_issuer.
// slave  : the issuer's view (accepts requests, drives the FPU, returns responses).
// master : the requester/FPU-stub view.
interface fpu_issuer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_funct;
  logic [31:0] req_a;
  logic [31:0] req_b;

  logic [1:0]  fpu_funct;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [31:0] fpu_o;
  logic        fpu_finish;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_funct;
  logic        rsp_timeout;

  logic        busy;

  modport slave (
    input  req_valid, req_funct, req_a, req_b,
    output req_ready,
    output fpu_funct, fpu_a, fpu_b,
    input  fpu_o, fpu_finish,
    output rsp_valid, rsp_data, rsp_funct, rsp_timeout,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req_valid, req_funct, req_a, req_b,
    input  req_ready,
    input  fpu_funct, fpu_a, fpu_b,
    output fpu_o, fpu_finish,
    input  rsp_valid, rsp_data, rsp_funct, rsp_timeout,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/fpu_issuer.sv
// fpu_issuer: issues one FPU operation per request, waits for the FPU's
// level finish (ignoring it for SETTLE_CYCLES after issue), captures the
// result and returns it on a valid/ready response channel, with a timeout
// abort returning quiet NaN.
// Optional build macro: FPU_ISSUER_STATS_EN adds stat_ops / stat_timeouts.
module fpu_issuer #(
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  fpu_issuer_if.slave     bus
`ifdef FPU_ISSUER_STATS_EN
  ,
  output logic [15:0]     stat_ops,
  output logic [15:0]     stat_timeouts
`endif
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LIMIT  = TW'(TIMEOUT_CYCLES);
  localparam logic [31:0]   QNAN        = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    WAIT,
    CAPTURE,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    settle_cnt;
  logic [TW-1:0] wait_cnt;
  logic          settle_done;
  logic          timeout_hit;

  assign settle_done = (settle_cnt == SETTLE_LAST);
  // wait_cnt holds the number of WAIT samples already seen without finish;
  // the abort fires on the sample after TIMEOUT_CYCLES misses, which puts
  // rsp_valid at SETTLE_CYCLES+TIMEOUT_CYCLES+1 cycles after acceptance.
  assign timeout_hit = (wait_cnt == WAIT_LIMIT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; finish takes priority over the timeout limit
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.req_valid)  state_nxt = SETTLE;
      SETTLE:  if (settle_done)    state_nxt = WAIT;
      WAIT: begin
        if (bus.fpu_finish)        state_nxt = CAPTURE;
        else if (timeout_hit)      state_nxt = RESP;
      end
      CAPTURE:                     state_nxt = RESP;
      RESP:    if (bus.rsp_ready)  state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
    bus.busy      = (state != IDLE);
  end

  // Operand, counter and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.fpu_funct   <= '0;
      bus.fpu_a       <= '0;
      bus.fpu_b       <= '0;
      bus.rsp_data    <= '0;
      bus.rsp_funct   <= '0;
      bus.rsp_timeout <= 1'b0;
      settle_cnt      <= '0;
      wait_cnt        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.fpu_funct <= bus.req_funct;
            bus.fpu_a     <= bus.req_a;
            bus.fpu_b     <= bus.req_b;
            settle_cnt    <= '0;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settle_done) wait_cnt <= '0;
        end
        WAIT: begin
          if (!bus.fpu_finish) begin
            if (timeout_hit) begin
              bus.rsp_data    <= QNAN;
              bus.rsp_funct   <= bus.fpu_funct;
              bus.rsp_timeout <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        CAPTURE: begin
          bus.rsp_data    <= bus.fpu_o;
          bus.rsp_funct   <= bus.fpu_funct;
          bus.rsp_timeout <= 1'b0;
        end
        RESP: ;
        default: ;
      endcase
    end
  end

`ifdef FPU_ISSUER_STATS_EN
  // Saturating completion / timeout counters on the response handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops      <= '0;
      stat_timeouts <= '0;
    end else if (state == RESP && bus.rsp_ready) begin
      if (stat_ops != '1) stat_ops <= stat_ops + 16'd1;
      if (bus.rsp_timeout && stat_timeouts != '1)
        stat_timeouts <= stat_timeouts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_issuer.sv
// Self-checking bench for fpu_issuer: directed cases from the test plan plus
// randomized operations against a latency/result reference model, with an
// in-bench FPU stub that can hold a stale finish across issue.
module tb_fpu_issuer;
  localparam int unsigned S = 2;
  localparam int unsigned T = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_issuer_if bus();

`ifdef FPU_ISSUER_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_timeouts;
`endif

  fpu_issuer #(
    .SETTLE_CYCLES (S),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef FPU_ISSUER_STATS_EN
    ,
    .stat_ops     (stat_ops),
    .stat_timeouts(stat_timeouts)
`endif
  );

  int checks = 0;
  int failures = 0;
  int exp_ops = 0;
  int exp_tmo = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"},   32'(bus.req_ready),   32'd1);
    check({tag, "_rsp_valid"},   32'(bus.rsp_valid),   32'd0);
    check({tag, "_rsp_data"},    bus.rsp_data,         32'd0);
    check({tag, "_rsp_funct"},   32'(bus.rsp_funct),   32'd0);
    check({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'd0);
    check({tag, "_fpu_funct"},   32'(bus.fpu_funct),   32'd0);
    check({tag, "_fpu_a"},       bus.fpu_a,            32'd0);
    check({tag, "_fpu_b"},       bus.fpu_b,            32'd0);
    check({tag, "_busy"},        32'(bus.busy),        32'd0);
  endtask

  // d: cycles after acceptance at which the stub raises finish (0 = never).
  // stale_len: finish still high from the previous op for this many cycles.
  task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int d, input int stale_len,
                        input int bp, input bit press);
    int first;
    int lat_exp;
    bit tmo;
    int j;
    bit drift;
    logic [31:0] held;
    // Reference: finish is honoured from the first WAIT sample (S+1) up to
    // and including the abort sample (S+T+1); capture adds one cycle.
    first = (d > int'(S) + 1) ? d : int'(S) + 1;
    if (d > 0 && first <= int'(S + T) + 1) begin
      tmo = 1'b0;
      lat_exp = first + 1;
    end else begin
      tmo = 1'b1;
      lat_exp = int'(S + T) + 1;
    end
    drift = 1'b0;

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_funct = f;
    bus.req_a = a;
    bus.req_b = b;
    check("idle_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    if (press) begin
      bus.req_funct = ~f;
      bus.req_a = ~a;
      bus.req_b = ~b;
    end else begin
      bus.req_valid = 1'b0;
    end
    check("issue_fpu_a", bus.fpu_a, a);
    check("issue_fpu_b", bus.fpu_b, b);
    check("issue_fpu_funct", 32'(bus.fpu_funct), 32'(f));
    check("issue_busy", 32'(bus.busy), 32'd1);

    j = 0;
    while (!bus.rsp_valid && j < int'(S + T) + 10) begin
      @(negedge clk);
      j++;
      bus.fpu_finish = (d > 0 && j >= d) || (j <= stale_len);
      if (d > 0 && j == d) bus.fpu_o = res;
      @(posedge clk); #1;
      if (bus.fpu_a !== a || bus.fpu_b !== b || bus.fpu_funct !== f || bus.req_ready !== 1'b0)
        drift = 1'b1;
    end
    check("latency", 32'(j), 32'(lat_exp));
    check("rsp_data", bus.rsp_data, tmo ? 32'h7FC0_0000 : res);
    check("rsp_funct", 32'(bus.rsp_funct), 32'(f));
    check("rsp_timeout", 32'(bus.rsp_timeout), 32'(tmo));

    held = bus.rsp_data;
    repeat (bp) begin
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== held || bus.req_ready !== 1'b0 ||
          bus.fpu_a !== a)
        drift = 1'b1;
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    exp_ops++;
    if (tmo) exp_tmo++;
    check("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("post_req_ready", 32'(bus.req_ready), 32'd1);
    check("post_busy", 32'(bus.busy), 32'd0);
    check("post_fpu_a_held", bus.fpu_a, a);
    check("hold_stable", 32'(drift), 32'd0);
`ifdef FPU_ISSUER_STATS_EN
    check("stat_ops", 32'(stat_ops), 32'(exp_ops));
    check("stat_timeouts", 32'(stat_timeouts), 32'(exp_tmo));
`endif
  endtask

  task automatic reset_mid_op();
    bit seen;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_funct = 2'd1;
    bus.req_a = 32'h1234_5678;
    bus.req_b = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (S + 3) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    bus.fpu_finish = 1'b0;
    exp_ops = 0;
    exp_tmo = 0;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
    end
    check("midrst_no_response", 32'(seen), 32'd0);
`ifdef FPU_ISSUER_STATS_EN
    check("midrst_stat_ops", 32'(stat_ops), 32'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pick;
    int d;
    bus.req_valid = 1'b0;
    bus.req_funct = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.fpu_o = '0;
    bus.fpu_finish = 1'b0;
    bus.rsp_ready = 1'b0;
    #22;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Add with finish 2 cycles after issue: minimum latency 4
    run_op(2'd0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 2, 0, 0, 1'b0);
    // Multiply then divide back-to-back; multiply's finish is still high
    // (with its result on fpu_o) during the divide's settle window
    run_op(2'd3, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3, 0, 0, 1'b0);
    run_op(2'd2, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 5, int'(S), 0, 1'b0);
    // Finish never arrives: abort with quiet NaN after S+T+1 cycles
    run_op(2'd1, 32'h4120_0000, 32'h3F00_0000, 32'hDEAD_BEEF, 0, int'(S), 0, 1'b0);
    // Finish on the abort sample wins; one cycle later it loses
    run_op(2'd0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, int'(S + T) + 1, 0, 0, 1'b0);
    run_op(2'd3, 32'h4444_4444, 32'h5555_5555, 32'h6666_6666, int'(S + T) + 2, 0, 0, 1'b0);
    // Backpressure with a competing request held valid
    run_op(2'd2, 32'hC000_0000, 32'h4080_0000, 32'hBF00_0000, 4, 1, 5, 1'b1);

    reset_mid_op();
    run_op(2'd0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 6, 0, 1, 1'b0);

    for (int n = 0; n < 20; n++) begin
      pick = $urandom_range(0, 9);
      if (pick == 0)      d = 0;
      else if (pick == 1) d = int'(S + T) + 1;
      else                d = $urandom_range(1, 12);
      run_op(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, d,
             $urandom_range(0, S), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
